// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_fifo                                                 |
// | Brief    : Elastic valid/ready pipeline stage backed by a DEPTH-entry      |
// |            circular buffer, with synchronous flush and occupancy output.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_stage_fifo #(
    parameter int                DATA_W          = 64,
    parameter int                DEPTH           = 2,
    parameter bit                BUBBLE_ON_EMPTY = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE    = {32'h8000_0000, 32'h0000_0013}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [DATA_W-1:0]            i_data,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [DATA_W-1:0]            o_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign i_ready = (r_count != c_FULL);
    assign o_valid = (r_count != '0);
    assign count   = r_count;
    assign w_push  = i_valid & i_ready & ~flush;
    assign w_pop   = o_valid & o_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush leaves payloads in place; they stay hidden behind o_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= BUBBLE_VALUE;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    generate
        if (BUBBLE_ON_EMPTY) begin : g_bubble
            assign o_data = o_valid ? r_mem[r_rd_ptr] : BUBBLE_VALUE;
        end else begin : g_no_bubble
            assign o_data = r_mem[r_rd_ptr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_stage_fifo                                              |
// | Brief    : Scoreboard bench for pipe_stage_fifo, DEPTH=2 and DEPTH=3       |
// |            instances driven by shared stimulus.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_fifo;

    localparam logic [63:0] BUBBLE = 64'h8000_0000_0000_0013;
    localparam logic [63:0] POISON = 64'hDEAD_BEEF_0000_0013;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        flush   = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready = 1'b0;
    logic [63:0] i_data  = '0;

    logic        i_ready [2];
    logic        o_valid [2];
    logic [63:0] o_data  [2];
    logic [1:0]  count   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Expected contents of each stage, oldest first.
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];

    pipe_stage_fifo #(.DATA_W(64), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready[0]), .i_data(i_data),
        .o_valid(o_valid[0]), .o_ready(o_ready), .o_data(o_data[0]),
        .count(count[0])
    );

    pipe_stage_fifo #(.DATA_W(64), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready[1]), .i_data(i_data),
        .o_valid(o_valid[1]), .o_ready(o_ready), .o_data(o_data[1]),
        .count(count[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), 64'(o_valid[k]), 64'd0);
            chk($sformatf("%s_ready%0d", tag, k), 64'(i_ready[k]), 64'd1);
            chk($sformatf("%s_count%0d", tag, k), 64'(count[k]), 64'd0);
            chk($sformatf("%s_data%0d", tag, k), o_data[k], BUBBLE);
        end
    endtask

    // Monitor: compares state against the queue model, then applies the
    // transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        logic [63:0] q[$];
        int          d;
        int          sz;
        bit          pu;
        bit          po;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 2 : 3;
            if (k == 0) q = exp_q0; else q = exp_q1;
            if (!rst_n) begin
                q.delete();
                chk($sformatf("rst_valid%0d", k), 64'(o_valid[k]), 64'd0);
                chk($sformatf("rst_count%0d", k), 64'(count[k]), 64'd0);
                chk($sformatf("rst_data%0d", k), o_data[k], BUBBLE);
            end else begin
                sz = q.size();
                chk($sformatf("count%0d", k), 64'(count[k]), 64'(sz));
                chk($sformatf("bound%0d", k), 64'(count[k] <= 2'(d)), 64'd1);
                chk($sformatf("o_valid%0d", k), 64'(o_valid[k]), 64'(sz != 0));
                chk($sformatf("i_ready%0d", k), 64'(i_ready[k]), 64'(sz != d));
                chk($sformatf("o_data%0d", k), o_data[k], (sz != 0) ? q[0] : BUBBLE);
                pu = i_valid && (sz != d) && !flush;
                po = (sz != 0) && o_ready && !flush;
                if (flush) begin
                    q.delete();
                end else begin
                    if (po) begin
                        chk($sformatf("xfer%0d", k), o_data[k], q[0]);
                        void'(q.pop_front());
                    end
                    if (pu) q.push_back(i_data);
                end
            end
            if (k == 0) exp_q0 = q; else exp_q1 = q;
        end
    end

    initial begin
        int n;
        // Power-on reset
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Streaming with downstream always ready
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'h8000_0000_0000_0093; step();
        i_data  = 64'h8000_0004_0010_0113; step();
        i_data  = 64'h8000_0008_0020_0193; step();
        i_valid = 1'b0;
        repeat (3) step();

        // Back-pressure: third item held upstream until space frees
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h1111_0000_0000_0001; step();
        i_data  = 64'h2222_0000_0000_0002; step();
        i_data  = 64'h3333_0000_0000_0003;
        repeat (3) step();
        o_ready = 1'b1;
        n = 0;
        while (!i_ready[0] && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL bp_timeout: i_ready stayed 0 for %0d cycles, expected 1", n);
        end
        step();
        i_valid = 1'b0;
        repeat (5) step();

        // Flush while holding two entries, poison payload offered same cycle
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h4444_0000_0000_0004; step();
        i_data  = 64'h5555_0000_0000_0005; step();
        flush   = 1'b1;
        i_data  = POISON;
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        check_empty("flush");
        o_ready = 1'b1;
        repeat (3) step();

        // Full with simultaneous pop: input waits one edge
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h6666_0000_0000_0006; step();
        i_data  = 64'h7777_0000_0000_0007; step();
        o_ready = 1'b1;
        i_data  = 64'h8888_0000_0000_0008;
        step();
        chk("full_pop_count", 64'(count[0]), 64'd1);
        o_ready = 1'b0;
        step();
        chk("full_refill_count", 64'(count[0]), 64'd2);
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (5) step();

        // Randomized traffic, exercises pointer wrap on both depths
        for (int c = 0; c < 300; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = ($urandom_range(0, 3) != 0);
            i_data  = {$urandom, $urandom};
            flush   = ($urandom_range(0, 31) == 0);
            step();
        end
        flush   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (5) step();

        // Reset asserted mid-traffic with two entries stored
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h9999_0000_0000_0009; step();
        i_data  = 64'hAAAA_0000_0000_000A; step();
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_empty("async_rst");
        repeat (3) step();
        rst_n   = 1'b1;
        step();
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'hBBBB_0000_0000_000B; step();
        i_valid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
